muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It takes the same forwarded operand pair as the ALU and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. HI/LO also accept MTHI/MTLO writes, and the EX result mux reads them for MFHI/MFLO. While the unit is busy, the hazard unit stalls IF/ID/EX on `busy`.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles from start to HI/LO commit; MTHI/MTLO write HI/LO directly.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sgn_a;
  logic               sgn_b;
  logic               b_zero;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  // Multiply: {partial product, multiplier}. Divide: low half holds dividend bits / quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               accept;
  logic               last;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept = (state == IDLE) && start && !flush;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state != IDLE);

  assign neg_a = !op[0] && in0[WIDTH-1];
  assign neg_b = !op[0] && in1[WIDTH-1];
  assign mag_a = neg_a ? -in0 : in0;
  assign mag_b = neg_b ? -in1 : in1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last)   state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // One iteration step for each operation class.
  always_comb begin
    addend    = acc[0] ? opa : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ge    = !div_diff[WIDTH+1];
  end

  // Sign correction; a zero divisor yields an all-ones quotient regardless of sign.
  always_comb begin
    prod_fix = (sgn_a ^ sgn_b) ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    rmd      = rem[WIDTH-1:0];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = sgn_a ? -rmd : rmd;
      res_lo = b_zero ? '1 : ((sgn_a ^ sgn_b) ? -quo : quo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      b_zero <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= (state == FIX) && !flush;
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_div <= op[1];
            sgn_a  <= neg_a;
            sgn_b  <= neg_b;
            b_zero <= (in1 == '0);
            opa    <= mag_a;
            opb    <= mag_b;
            cnt    <= '0;
            rem    <= '0;
            acc    <= op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          end else if (!start) begin
            if (hi_we) hi <= in0;
            if (lo_we) lo <= in0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!is_div) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem             <= div_ge ? div_diff[WIDTH:0] : div_shift;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// back-to-back issue, MTHI/MTLO, flush, mid-operation reset and start-while-busy.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        hi_we;
  logic        lo_we;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchk;
  int nerr;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following posedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in0   = a;
    in1   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy-high negedges until done is seen, bounded.
  task automatic wait_done(output int busy_cyc, output logic ok);
    int n;
    busy_cyc = 0;
    ok       = 1'b0;
    n        = 0;
    while (!ok && n < 100) begin
      if (done) begin
        ok = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int   cyc;
    logic ok;
    launch(o, a, b);
    wait_done(cyc, ok);
    check({tag, "_done"}, 64'(ok), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int   cyc;
    int   seen;
    logic ok;
    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    in0   = '0;
    in1   = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    check("mult_done_pulse", 64'(done), 64'd0);

    // MULTU then DIVU issued on the done cycle.
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, ok);
    check("multu_done", 64'(ok), 64'd1);
    check("multu_lat", 64'(cyc), 64'd33);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    launch(OP_DIVU, 32'd100, 32'd7);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(cyc, ok);
    check("divu_done", 64'(ok), 64'd1);
    check("divu_lat", 64'(cyc), 64'd33);
    check("divu_hi", 64'(hi), 64'd2);
    check("divu_lo", 64'(lo), 64'd14);
    @(negedge clk);

    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    @(negedge clk);
    run_op("divu_5d0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op("div_m5d0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op("mult_m6xm5", OP_MULT, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'd0, 32'd30);
    @(negedge clk);

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1;
    in0   = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h0000_1234);
    check("mthi_lo_kept", 64'(lo), 64'd30);
    lo_we = 1'b1;
    in0   = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0000_5678);

    // Flush at cycle 10 of MULT 3*4.
    launch(OP_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(hi), 64'h0000_1234);
    check("flush_lo", 64'(lo), 64'h0000_5678);

    // start while busy is ignored.
    launch(OP_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc, ok);
    check("ign_done", 64'(ok), 64'd1);
    check("ign_lat", 64'(cyc), 64'd28);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd12);
    @(negedge clk);
    check("ign_idle", 64'(busy), 64'd0);
    check("ign_done_pulse", 64'(done), 64'd0);

    // Asynchronous reset mid-operation.
    launch(OP_MULT, 32'd3, 32'd4);
    repeat (19) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_mult", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
